// File: rtl/line_burst_mem.sv
// line_burst_mem: main-memory responder behind a cache line-fill/writeback port.
// Whole-line bursts of BEAT_BYTES-wide beats, beat order 0..BEATS-1, with separate
// programmable read/write access latency and saturating completed-burst counters.
// Storage is never reset so that data survives a controller reset.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for mem_req; busy=0
// LAT    | access latency countdown (lat_cnt down to terminal count 0)
// RBURST | presenting read beats, one per cycle, rvalid=1
// WBURST | consuming write beats, one per cycle, ready=1
// DONE   | burst complete; waiting for mem_req to drop before re-arming
module line_burst_mem #(
    parameter int ADDR_BITS  = 16,
    parameter int LINE_BYTES = 64,
    parameter int BEAT_BYTES = 8,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic                    mem_wr,
    input  logic [ADDR_BITS-1:0]    mem_addr,
    input  logic [8*BEAT_BYTES-1:0] mem_wdata,
    output logic [8*BEAT_BYTES-1:0] rdata,
    output logic                    rvalid,
    output logic                    ready,
    output logic                    last,
    output logic                    busy,
    output logic [15:0]             rd_bursts,
    output logic [15:0]             wr_bursts
);

    localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int DW     = 8 * BEAT_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = ADDR_BITS - OFF_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WORD_W = LINE_W + BEAT_W;
    localparam int WORDS  = 1 << WORD_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [7:0]        RD_LAT_LOAD = (RD_LATENCY == 0) ? 8'd0 : 8'(RD_LATENCY - 1);
    localparam logic [7:0]        WR_LAT_LOAD = (WR_LATENCY == 0) ? 8'd0 : 8'(WR_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAT    = 3'd1,
        RBURST = 3'd2,
        WBURST = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state;
    logic [LINE_W-1:0]   line_q;
    logic                wr_q;
    logic [7:0]          lat_cnt;
    logic [BEAT_W-1:0]   beat;
    logic [DW-1:0]       mem [WORDS];

    logic [LINE_W-1:0]   acc_line;
    logic [LINE_W-1:0]   start_line;
    logic [BEAT_W-1:0]   next_beat;
    logic                lat_zero;
    logic                start_go;
    logic                start_wr;
    logic                mem_we;
    logic                unused_addr_bits;

    // Offset bits within a line carry no information for a whole-line burst.
    assign unused_addr_bits = ^mem_addr[OFF_W-1:0];

    // Burst launch: straight from IDLE when the selected latency is zero,
    // otherwise from LAT once the countdown reaches its terminal count.
    always_comb begin
        acc_line   = mem_addr[ADDR_BITS-1:OFF_W];
        next_beat  = beat + BEAT_W'(1);
        lat_zero   = mem_wr ? (WR_LATENCY == 0) : (RD_LATENCY == 0);
        start_wr   = (state == IDLE) ? mem_wr : wr_q;
        start_line = (state == IDLE) ? acc_line : line_q;
        start_go   = mem_req && (((state == IDLE) && lat_zero) ||
                                 ((state == LAT) && (lat_cnt == 8'd0)));
        mem_we     = (state == WBURST) && mem_req;
    end

    // Write port: one beat per ready edge; an abort edge writes nothing.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{line_q, beat}] <= mem_wdata;
        end
    end

    // Sequencer with registered strobes, beat index and burst counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            line_q    <= '0;
            wr_q      <= 1'b0;
            lat_cnt   <= 8'd0;
            beat      <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            ready     <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            rd_bursts <= 16'd0;
            wr_bursts <= 16'd0;
        end else if (start_go) begin
            line_q <= start_line;
            wr_q   <= start_wr;
            beat   <= '0;
            busy   <= 1'b1;
            last   <= 1'b0;
            if (start_wr) begin
                state  <= WBURST;
                ready  <= 1'b1;
                rvalid <= 1'b0;
            end else begin
                state  <= RBURST;
                rvalid <= 1'b1;
                ready  <= 1'b0;
                rdata  <= mem[{start_line, BEAT_W'(0)}];
            end
        end else begin
            case (state)
                IDLE: begin
                    rvalid <= 1'b0;
                    ready  <= 1'b0;
                    last   <= 1'b0;
                    if (mem_req) begin
                        line_q  <= acc_line;
                        wr_q    <= mem_wr;
                        lat_cnt <= mem_wr ? WR_LAT_LOAD : RD_LAT_LOAD;
                        busy    <= 1'b1;
                        state   <= LAT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LAT: begin
                    if (!mem_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                RBURST: begin
                    if (!mem_req) begin
                        state  <= IDLE;
                        rvalid <= 1'b0;
                        last   <= 1'b0;
                        busy   <= 1'b0;
                    end else if (last) begin
                        rvalid <= 1'b0;
                        last   <= 1'b0;
                        state  <= DONE;
                        if (rd_bursts != 16'hFFFF) rd_bursts <= rd_bursts + 16'd1;
                    end else begin
                        rdata <= mem[{line_q, next_beat}];
                        beat  <= next_beat;
                        last  <= (next_beat == LAST_BEAT);
                    end
                end
                WBURST: begin
                    if (!mem_req) begin
                        state <= IDLE;
                        ready <= 1'b0;
                        last  <= 1'b0;
                        busy  <= 1'b0;
                    end else if (last) begin
                        ready <= 1'b0;
                        last  <= 1'b0;
                        beat  <= next_beat;
                        state <= DONE;
                        if (wr_bursts != 16'hFFFF) wr_bursts <= wr_bursts + 16'd1;
                    end else begin
                        beat <= next_beat;
                        last <= (next_beat == LAST_BEAT);
                    end
                end
                DONE: begin
                    if (!mem_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rvalid <= 1'b0;
                    ready  <= 1'b0;
                    last   <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_burst_mem.sv
// tb_line_burst_mem: directed scenarios plus randomized bursts for line_burst_mem.
// Expected outputs come from a timing model keyed on cycles since accept, with a
// word-array image of memory; a second instance covers zero-latency timing.
module tb_line_burst_mem;

    localparam int BEATS = 8;
    localparam int RD_L  = 4;
    localparam int WR_L  = 2;
    localparam int BIG   = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_wr;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata, rdata;
    logic        rvalid, ready, last, busy;
    logic [15:0] rd_bursts, wr_bursts;

    logic        z_req, z_wr;
    logic [11:0] z_addr;
    logic [63:0] z_wdata, z_rdata;
    logic        z_rvalid, z_ready, z_last, z_busy;
    logic [15:0] z_rd_bursts, z_wr_bursts;

    always #5 clk = ~clk;

    line_burst_mem #(.ADDR_BITS(16), .LINE_BYTES(64), .BEAT_BYTES(8),
                     .RD_LATENCY(RD_L), .WR_LATENCY(WR_L)) u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rdata(rdata),
        .rvalid(rvalid), .ready(ready), .last(last), .busy(busy),
        .rd_bursts(rd_bursts), .wr_bursts(wr_bursts));

    line_burst_mem #(.ADDR_BITS(12), .LINE_BYTES(64), .BEAT_BYTES(8),
                     .RD_LATENCY(0), .WR_LATENCY(0)) u_dut_z (
        .clk(clk), .rst(rst), .mem_req(z_req), .mem_wr(z_wr),
        .mem_addr(z_addr), .mem_wdata(z_wdata), .rdata(z_rdata),
        .rvalid(z_rvalid), .ready(z_ready), .last(z_last), .busy(z_busy),
        .rd_bursts(z_rd_bursts), .wr_bursts(z_wr_bursts));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Reference model: memory image plus the currently active transaction.
    logic [63:0] mdl [8192];
    bit          known [8192];
    logic [63:0] tx_wbeat [BEATS];
    int          t_a, t_L, t_line, t_drop;
    bit          t_act, t_wr;
    int          base_rd = 0;
    int          base_wr = 0;

    logic [63:0] cap_rd [64];
    bit          cap_rv [64], cap_rdy [64], cap_last [64], cap_busy [64];

    // Per-cycle comparison of every main-DUT output against the model.
    always @(negedge clk) begin : mon
        int n, d, k, idx, e_rc, e_wc;
        logic e_rv, e_rdy, e_last, e_busy;
        if (rst) begin
            n = cyc;
            if (t_act && n >= t_drop) begin
                if (t_drop > t_a + t_L + BEATS) begin
                    if (t_wr) base_wr = sat16(base_wr + 1);
                    else      base_rd = sat16(base_rd + 1);
                end
                t_act = 1'b0;
            end
            e_rv = 0; e_rdy = 0; e_last = 0; e_busy = 0;
            e_rc = base_rd; e_wc = base_wr; idx = 0;
            if (t_act) begin
                d = n - t_a;
                k = d - t_L;
                e_busy = 1;
                if (t_wr && k >= 1 && k <= BEATS) begin
                    mdl[t_line*BEATS + k - 1]   = tx_wbeat[k-1];
                    known[t_line*BEATS + k - 1] = 1'b1;
                end
                if (k >= 0 && k < BEATS) begin
                    if (t_wr) e_rdy = 1; else e_rv = 1;
                    e_last = (k == BEATS - 1);
                    idx = t_line*BEATS + k;
                end
                if (d >= t_L + BEATS) begin
                    if (t_wr) e_wc = sat16(base_wr + 1);
                    else      e_rc = sat16(base_rd + 1);
                end
            end
            chk("rvalid", 64'(rvalid), 64'(e_rv));
            chk("ready", 64'(ready), 64'(e_rdy));
            chk("last", 64'(last), 64'(e_last));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("rd_bursts", 64'(rd_bursts), 64'(e_rc));
            chk("wr_bursts", 64'(wr_bursts), 64'(e_wc));
            if (e_rv && known[idx]) chk("rdata", rdata, mdl[idx]);
        end
    end

    task automatic fill_pattern(input logic [63:0] base);
        for (int k = 0; k < BEATS; k++) tx_wbeat[k] = base | 64'(k);
    endtask

    task automatic fill_random();
        for (int k = 0; k < BEATS; k++) tx_wbeat[k] = {$urandom, $urandom};
    endtask

    // One burst from accept to the cycle after mem_req is seen low; abort_d > 0
    // drops mem_req so that the edge abort_d cycles after accept sees it low.
    task automatic run_txn(input bit wr, input logic [15:0] addr, input int abort_d, input int hold);
        int L, a, end_d, j;
        L = wr ? WR_L : RD_L;
        end_d = (abort_d > 0) ? abort_d : L + BEATS + 1 + hold;
        mem_addr = addr; mem_wr = wr; mem_wdata = tx_wbeat[0]; mem_req = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        t_a = a; t_L = L; t_wr = wr; t_line = int'(addr[15:6]); t_drop = BIG; t_act = 1'b1;
        for (int d = 0; d < 64; d++) begin
            cap_rv[d] = rvalid; cap_rdy[d] = ready; cap_last[d] = last;
            cap_busy[d] = busy; cap_rd[d] = rdata;
            if (d == end_d) break;
            if (d + 1 == end_d) begin
                mem_req = 1'b0;
                t_drop = a + end_d;
            end
            j = d - L;
            if (j >= 0 && j < BEATS) mem_wdata = tx_wbeat[j];
            mem_addr = 16'($urandom);
            mem_wr = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    logic [63:0] ff80_b [BEATS];
    logic [63:0] ffc0_b [BEATS];
    logic [63:0] zb [BEATS];

    initial begin
        rst = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
        z_req = 1'b0; z_wr = 1'b0; z_addr = '0; z_wdata = '0;
        t_act = 1'b0; t_drop = BIG;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_last", 64'(last), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rd_bursts", 64'(rd_bursts), 64'd0);
        chk("reset_wr_bursts", 64'(wr_bursts), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Write then read line 0x0040, with latency pins.
        fill_pattern(64'h1111_0000_0000_0000);
        run_txn(1'b1, 16'h0040, 0, 0);
        chk("wr_lat_ready_d1", 64'(cap_rdy[1]), 64'd0);
        chk("wr_lat_ready_d2", 64'(cap_rdy[2]), 64'd1);
        chk("wr_last_d9", 64'(cap_last[9]), 64'd1);
        run_txn(1'b0, 16'h0040, 0, 0);
        chk("rd_lat_rvalid_d3", 64'(cap_rv[3]), 64'd0);
        chk("rd_lat_rvalid_d4", 64'(cap_rv[4]), 64'd1);
        chk("rd_beat0", cap_rd[4], 64'h1111_0000_0000_0000);
        chk("rd_beat7", cap_rd[11], 64'h1111_0000_0000_0007);
        chk("rd_last_d10", 64'(cap_last[10]), 64'd0);
        chk("rd_last_d11", 64'(cap_last[11]), 64'd1);
        chk("rd_bursts_1", 64'(rd_bursts), 64'd1);
        chk("wr_bursts_1", 64'(wr_bursts), 64'd1);

        // Unaligned address selects the containing line.
        run_txn(1'b0, 16'h007F, 0, 0);
        chk("unaligned_beat0", cap_rd[4], 64'h1111_0000_0000_0000);
        chk("unaligned_beat4", cap_rd[8], 64'h1111_0000_0000_0004);

        // Top line writeback leaves the neighbouring line intact.
        fill_random();
        for (int k = 0; k < BEATS; k++) ff80_b[k] = tx_wbeat[k];
        run_txn(1'b1, 16'hFF80, 0, 0);
        fill_random();
        for (int k = 0; k < BEATS; k++) ffc0_b[k] = tx_wbeat[k];
        run_txn(1'b1, 16'hFFC0, 0, 0);
        run_txn(1'b0, 16'hFF80, 0, 0);
        chk("ff80_beat7", cap_rd[11], ff80_b[7]);
        run_txn(1'b0, 16'hFFC0, 0, 0);
        chk("ffc0_beat0", cap_rd[4], ffc0_b[0]);
        chk("ffc0_beat7", cap_rd[11], ffc0_b[7]);

        // Request held 10 cycles past the burst: no re-accept, busy stays high.
        run_txn(1'b0, 16'h0040, 0, 10);
        for (int d = 0; d < RD_L + BEATS + 11; d++) chk($sformatf("hold_busy_d%0d", d), 64'(cap_busy[d]), 64'd1);
        for (int d = RD_L + BEATS; d < RD_L + BEATS + 11; d++) chk($sformatf("hold_rvalid_d%0d", d), 64'(cap_rv[d]), 64'd0);
        chk("hold_busy_drop", 64'(cap_busy[RD_L + BEATS + 11]), 64'd0);

        // Write aborted after three ready beats.
        fill_pattern(64'hAAAA_0000_0000_0000);
        run_txn(1'b1, 16'h0100, 0, 0);
        fill_pattern(64'hBBBB_0000_0000_0000);
        run_txn(1'b1, 16'h0100, WR_L + 1 + 3, 0);
        chk("abort_busy", 64'(cap_busy[WR_L + 4]), 64'd0);
        chk("abort_wr_bursts", 64'(wr_bursts), 64'd4);
        run_txn(1'b0, 16'h0100, 0, 0);
        chk("abort_beat0", cap_rd[4], 64'hBBBB_0000_0000_0000);
        chk("abort_beat2", cap_rd[6], 64'hBBBB_0000_0000_0002);
        chk("abort_beat3", cap_rd[7], 64'hAAAA_0000_0000_0003);
        chk("abort_beat7", cap_rd[11], 64'hAAAA_0000_0000_0007);
        chk("abort_rd_bursts", 64'(rd_bursts), 64'd6);

        // Randomized traffic over lines 16..31 and the top line.
        for (int i = 0; i < 40; i++) begin
            bit wr;
            int line, ab, L;
            wr = 1'($urandom);
            line = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(16, 31));
            L = wr ? WR_L : RD_L;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, L + BEATS)) : 0;
            fill_random();
            run_txn(wr, {line[9:0], 6'($urandom)}, ab, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a read burst.
        mem_addr = 16'h0040; mem_wr = 1'b0; mem_req = 1'b1;
        @(posedge clk); #1;
        t_a = cyc; t_L = RD_L; t_wr = 1'b0; t_line = 1; t_drop = BIG; t_act = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("midrst_rvalid_before", 64'(rvalid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(rvalid), 64'd0);
        chk("midrst_last", 64'(last), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_bursts", 64'(rd_bursts), 64'd0);
        chk("midrst_wr_bursts", 64'(wr_bursts), 64'd0);
        t_act = 1'b0; base_rd = 0; base_wr = 0;
        mem_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 16'h0040, 0, 0);
        chk("postrst_beat3", cap_rd[7], 64'h1111_0000_0000_0003);
        chk("postrst_rd_bursts", 64'(rd_bursts), 64'd1);

        // Zero-latency instance: strobes appear in the cycle right after accept.
        for (int k = 0; k < BEATS; k++) zb[k] = 64'h2222_0000_0000_0000 | 64'(k);
        z_addr = 12'h080; z_wr = 1'b1; z_wdata = zb[0]; z_req = 1'b1;
        @(posedge clk); #1;
        chk("z_wr_ready_d0", 64'(z_ready), 64'd1);
        for (int k = 0; k < BEATS; k++) begin
            z_wdata = zb[k];
            if (k == BEATS - 1) chk("z_wr_last", 64'(z_last), 64'd1);
            @(posedge clk); #1;
        end
        chk("z_wr_done_ready", 64'(z_ready), 64'd0);
        chk("z_wr_bursts", 64'(z_wr_bursts), 64'd1);
        z_req = 1'b0;
        @(posedge clk); #1;
        chk("z_idle_busy", 64'(z_busy), 64'd0);
        z_wr = 1'b0; z_addr = 12'h0A5; z_req = 1'b1;
        @(posedge clk); #1;
        chk("z_rd_rvalid_d0", 64'(z_rvalid), 64'd1);
        chk("z_rd_beat0", z_rdata, zb[0]);
        repeat (7) begin @(posedge clk); #1; end
        chk("z_rd_last", 64'(z_last), 64'd1);
        chk("z_rd_beat7", z_rdata, zb[7]);
        @(posedge clk); #1;
        z_req = 1'b0;
        @(posedge clk); #1;
        chk("z_rd_bursts", 64'(z_rd_bursts), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
